// File: rtl/counter_wrap_tracker.sv
// counter_wrap_tracker: follows a mod-10 up/down counter, extends it into a multi-digit BCD count
// and queues wrap/jump events behind a valid/ready FIFO.
// Optional macro SEVEN_SEG_EN adds a registered seven-segment output SEG_OUT.
module counter_wrap_tracker #(
  parameter int unsigned TENS_DIGITS = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_0,
  input  logic [3:0]               COUNT_IN,
  input  logic                     CLR,
  output logic [4*TENS_DIGITS-1:0] TENS_OUT,
  output logic                     EVT_VALID,
  input  logic                     EVT_READY,
  output logic [1:0]               EVT_DATA,
  output logic                     EVT_DROP,
  output logic                     ERR
`ifdef SEVEN_SEG_EN
  ,
  output logic [7*(TENS_DIGITS+1)-1:0] SEG_OUT
`endif
);

  localparam int unsigned TW = 4 * TENS_DIGITS;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FullCnt = FIFO_DEPTH[AW:0];

  localparam logic [1:0] EvtNone = 2'b00;
  localparam logic [1:0] EvtUp   = 2'b01;
  localparam logic [1:0] EvtDown = 2'b10;
  localparam logic [1:0] EvtJump = 2'b11;

  logic [3:0]    prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic [TW-1:0] tens_q, tens_d, tens_inc, tens_dec;
  logic          err_q, err_d;
  logic          drop_q, drop_d;

  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;

  logic          legal, no_change;
  logic [1:0]    evt;
  logic          push, pop, full;

  // Classify the sampled count against the previous legal sample.
  always_comb begin
    legal     = (COUNT_IN <= 4'd9);
    no_change = (COUNT_IN == prev_q) || (COUNT_IN == prev_q + 4'd1) ||
                (COUNT_IN + 4'd1 == prev_q);
    evt       = EvtNone;
    if (!CLR && prev_valid_q) begin
      if (!legal) begin
        evt = EvtJump;
      end else if (no_change) begin
        evt = EvtNone;
      end else if (prev_q == 4'd9 && COUNT_IN == 4'd0) begin
        evt = EvtUp;
      end else if (prev_q == 4'd0 && COUNT_IN == 4'd9) begin
        evt = EvtDown;
      end else begin
        evt = EvtJump;
      end
    end
  end

  // BCD increment and decrement of the upper digits; all-9s and all-0s wrap silently.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] digit;
    tens_inc = '0;
    tens_dec = '0;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int i = 0; i < int'(TENS_DIGITS); i++) begin
      digit = tens_q[4*i +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          tens_inc[4*i +: 4] = 4'd0;
        end else begin
          tens_inc[4*i +: 4] = digit + 4'd1;
          carry              = 1'b0;
        end
      end else begin
        tens_inc[4*i +: 4] = digit;
      end
      if (borrow) begin
        if (digit == 4'd0) begin
          tens_dec[4*i +: 4] = 4'd9;
        end else begin
          tens_dec[4*i +: 4] = digit - 4'd1;
          borrow             = 1'b0;
        end
      end else begin
        tens_dec[4*i +: 4] = digit;
      end
    end
  end

  assign full      = (cnt_q == FullCnt);
  assign EVT_VALID = (cnt_q != '0);
  assign pop       = EVT_VALID && EVT_READY;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = (evt != EvtNone) && (!full || pop);

  // Next-state for tracking registers; CLR overrides everything.
  always_comb begin
    tens_d       = tens_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    err_d        = err_q;
    drop_d       = drop_q;
    if (CLR) begin
      tens_d       = '0;
      prev_valid_d = 1'b0;
      err_d        = 1'b0;
      drop_d       = 1'b0;
    end else begin
      if (legal) begin
        prev_d       = COUNT_IN;
        prev_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      if (evt == EvtUp) begin
        tens_d = tens_inc;
      end else if (evt == EvtDown) begin
        tens_d = tens_dec;
      end
      if (evt != EvtNone && !push) begin
        drop_d = 1'b1;
      end
    end
  end

  // Tracking state registers.
  always_ff @(posedge CLK or negedge RESET_0) begin
    if (!RESET_0) begin
      prev_q       <= 4'd0;
      prev_valid_q <= 1'b0;
      tens_q       <= '0;
      err_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      tens_q       <= tens_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge RESET_0) begin
    if (!RESET_0) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (CLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= evt;
  end

  assign EVT_DATA = EVT_VALID ? mem_q[rd_ptr_q] : 2'b00;
  assign TENS_OUT = tens_q;
  assign EVT_DROP = drop_q;
  assign ERR      = err_q;

`ifdef SEVEN_SEG_EN
  localparam int unsigned SW = 7 * (TENS_DIGITS + 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [SW-1:0] seg_q, seg_d;

  // Decode next-state digits so segments change on the same edge as TENS_OUT.
  always_comb begin
    seg_d      = '0;
    seg_d[6:0] = seg7(prev_d);
    for (int i = 0; i < int'(TENS_DIGITS); i++) begin
      seg_d[7*(i+1) +: 7] = seg7(tens_d[4*i +: 4]);
    end
  end

  // Segment register; every digit shows "0" out of reset.
  always_ff @(posedge CLK or negedge RESET_0) begin
    if (!RESET_0) begin
      seg_q <= {(TENS_DIGITS + 1){7'h3F}};
    end else begin
      seg_q <= seg_d;
    end
  end

  assign SEG_OUT = seg_q;
`endif

endmodule

// File: tb/tb_counter_wrap_tracker.sv
// Self-checking bench for counter_wrap_tracker (TENS_DIGITS=2, FIFO_DEPTH=4).
module tb_counter_wrap_tracker;

  logic       clk;
  logic       reset_0;
  logic [3:0] count_in;
  logic       clr;
  logic [7:0] tens_out;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_data;
  logic       evt_drop;
  logic       err;
`ifdef SEVEN_SEG_EN
  logic [20:0] seg_out;
`endif

  int errors = 0;
  int checks = 0;

  logic [1:0] sbq [$];
  logic       stall_prev = 1'b0;
  logic [1:0] held_data  = 2'b00;
  logic [1:0] exp_evt;

  counter_wrap_tracker #(
    .TENS_DIGITS(2),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK      (clk),
    .RESET_0  (reset_0),
    .COUNT_IN (count_in),
    .CLR      (clr),
    .TENS_OUT (tens_out),
    .EVT_VALID(evt_valid),
    .EVT_READY(evt_ready),
    .EVT_DATA (evt_data),
    .EVT_DROP (evt_drop),
    .ERR      (err)
`ifdef SEVEN_SEG_EN
    ,
    .SEG_OUT  (seg_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one sample; it is taken at the next rising edge, results visible #1 later.
  task automatic apply(input logic [3:0] v);
    count_in = v;
    @(posedge clk);
    #1;
  endtask

  // Counts 1..9 then 0 starting from a PREV of 0: one up-wrap.
  task automatic wrap_up(input bit expect_evt);
    for (int v = 1; v <= 9; v++) apply(4'(v));
    if (expect_evt) sbq.push_back(2'b01);
    apply(4'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted event, checks idle and stall behaviour.
  initial begin
    forever begin
      @(negedge clk);
      if (!evt_valid) begin
        chk("idle_data_zero", {30'd0, evt_data}, 32'd0);
      end else if (stall_prev) begin
        chk("stall_data_stable", {30'd0, evt_data}, {30'd0, held_data});
      end
      if (evt_valid && evt_ready) begin
        if (sbq.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_event: got %b, expected none at %0t", evt_data, $time);
        end else begin
          exp_evt = sbq.pop_front();
          chk("event_data", {30'd0, evt_data}, {30'd0, exp_evt});
        end
      end
      stall_prev = evt_valid && !evt_ready;
      held_data  = evt_data;
    end
  end

  initial begin
    reset_0   = 1'b0;
    clr       = 1'b0;
    count_in  = 4'd0;
    evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tens", {24'd0, tens_out}, 32'h00);
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_data", {30'd0, evt_data}, 32'd0);
    chk("rst_drop", {31'd0, evt_drop}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset_0 = 1'b1;

    // 0..9,0 gives a single up-wrap
    apply(4'd0);
    wrap_up(1'b1);
    chk("first_wrap_tens", {24'd0, tens_out}, 32'h01);
    chk("first_wrap_valid", {31'd0, evt_valid}, 32'd1);

    // down-wraps: 01 -> 00 -> 99, then back up to 00
    sbq.push_back(2'b10);
    apply(4'd9);
    chk("down_tens_00", {24'd0, tens_out}, 32'h00);
    for (int v = 8; v >= 0; v--) apply(4'(v));
    sbq.push_back(2'b10);
    apply(4'd9);
    chk("down_tens_99", {24'd0, tens_out}, 32'h99);
    sbq.push_back(2'b01);
    apply(4'd0);
    chk("up_99_to_00", {24'd0, tens_out}, 32'h00);

    // 100 up-wraps return TENS to 00
    for (int w = 1; w <= 100; w++) begin
      wrap_up(1'b1);
      if (w == 42) chk("tens_42", {24'd0, tens_out}, 32'h42);
    end
    chk("hundred_tens", {24'd0, tens_out}, 32'h00);
    chk("hundred_drop", {31'd0, evt_drop}, 32'd0);

    // full FIFO with consumer stalled: 5th event dropped, TENS still advances
    apply(4'd0);
    apply(4'd0);
    evt_ready = 1'b0;
    for (int w = 1; w <= 5; w++) wrap_up(w <= 4);
    chk("full_tens", {24'd0, tens_out}, 32'h05);
    chk("full_drop", {31'd0, evt_drop}, 32'd1);
    chk("full_valid", {31'd0, evt_valid}, 32'd1);
    for (int v = 1; v <= 9; v++) apply(4'(v));
    // push and pop in the same cycle on a full FIFO: new event must be kept
    evt_ready = 1'b1;
    sbq.push_back(2'b01);
    apply(4'd0);
    chk("pushpop_tens", {24'd0, tens_out}, 32'h06);
    repeat (6) apply(4'd0);
    chk("drained_valid", {31'd0, evt_valid}, 32'd0);
    chk("drained_queue", sbq.size(), 32'd0);

    // jumps and an illegal value
    sbq.push_back(2'b11);
    apply(4'd3);
    sbq.push_back(2'b11);
    apply(4'd7);
    chk("jump_tens", {24'd0, tens_out}, 32'h06);
    apply(4'd8);
    chk("pre_illegal_err", {31'd0, err}, 32'd0);
    sbq.push_back(2'b11);
    apply(4'd12);
    chk("illegal_err", {31'd0, err}, 32'd1);
    apply(4'd8);
    apply(4'd9);
    apply(4'd9);
    chk("illegal_err_sticky", {31'd0, err}, 32'd1);
    chk("illegal_tens", {24'd0, tens_out}, 32'h06);

    // CLR: first sample afterwards (9 -> 0 would be a wrap) is capture only
    clr = 1'b1;
    apply(4'd0);
    clr = 1'b0;
    chk("clr1_tens", {24'd0, tens_out}, 32'h00);
    chk("clr1_err", {31'd0, err}, 32'd0);
    chk("clr1_drop", {31'd0, evt_drop}, 32'd0);
    apply(4'd0);
    chk("clr1_capture_tens", {24'd0, tens_out}, 32'h00);
    for (int w = 1; w <= 42; w++) wrap_up(1'b1);
    chk("clr_setup_tens", {24'd0, tens_out}, 32'h42);
    evt_ready = 1'b0;
    sbq.push_back(2'b11);
    apply(4'd5);
    sbq.push_back(2'b11);
    apply(4'd2);
    sbq.push_back(2'b11);
    apply(4'd7);
    sbq.push_back(2'b11);
    apply(4'd3);
    apply(4'd12);
    chk("clr_setup_drop", {31'd0, evt_drop}, 32'd1);
    chk("clr_setup_err", {31'd0, err}, 32'd1);
    clr = 1'b1;
    sbq.delete();
    apply(4'd3);
    clr = 1'b0;
    chk("clr_tens", {24'd0, tens_out}, 32'h00);
    chk("clr_valid", {31'd0, evt_valid}, 32'd0);
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_drop", {31'd0, evt_drop}, 32'd0);
    apply(4'd5);
    evt_ready = 1'b1;
    apply(4'd6);
    apply(4'd6);
    chk("post_clr_no_event", {31'd0, evt_valid}, 32'd0);

    // asynchronous reset in the middle of a cycle
    evt_ready = 1'b0;
    sbq.push_back(2'b11);
    apply(4'd0);
    wrap_up(1'b1);
    sbq.push_back(2'b11);
    apply(4'd13);
    chk("pre_rst_tens", {24'd0, tens_out}, 32'h01);
    chk("pre_rst_err", {31'd0, err}, 32'd1);
    #3;
    reset_0 = 1'b0;
    sbq.delete();
    #1;
    chk("async_rst_tens", {24'd0, tens_out}, 32'h00);
    chk("async_rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("async_rst_err", {31'd0, err}, 32'd0);
    chk("async_rst_drop", {31'd0, evt_drop}, 32'd0);
    @(posedge clk);
    #1;
    reset_0 = 1'b1;
    apply(4'd4);
    evt_ready = 1'b1;
    apply(4'd4);
    apply(4'd5);
    chk("post_rst_no_event", {31'd0, evt_valid}, 32'd0);
    chk("final_queue_empty", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
